mk14_bus_arbiter: RTL and testbench
===================================

Name: mk14_bus_arbiter

Overview:
Owns the single MMU core-side port and shares it between three requesters: the SC/MP core, the Intel-HEX loader and a debug read/write port for a future UART monitor. Stalls the core via its enable, drains in-flight core cycles, serves loader/debug transactions, then hands the bus back. Sits between core/intel_hex/debug logic and mmu, and replaces the ad-hoc rx_wait muxing in the SoC.

Parameters:
ADDR_W, 16, address width of all ports
DATA_W, 8, data width
READ_LATENCY, 1, cycles from mem_addr valid to mem_read_data valid (1..3)
DRAIN_CYCLES, 2, cycles core_en held low before a non-core grant (1..7)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
core_run_req  in  1  SoC wants the core running
core_en  out  1  core enable
core_addr  in  ADDR_W  core address
core_write_en  in  1  core write strobe
core_write_data  in  DATA_W  core write data
ldr_valid  in  1  loader byte valid (pulse)
ldr_addr  in  ADDR_W  loader address
ldr_data  in  DATA_W  loader data
ldr_ready  out  1  loader holding register empty
dbg_req  in  1  debug request, held until dbg_ack
dbg_we  in  1  debug write (1) / read (0)
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  DATA_W  read data, valid with dbg_ack, held after
mem_addr  out  ADDR_W  to mmu
mem_write_en  out  1  to mmu
mem_write_data  out  DATA_W  to mmu
mem_read_data  in  DATA_W  from mmu
busy  out  1  non-core owner active (state != s_CORE)

Behaviour:
- Reset: state s_CORE, core_en 0, ldr_ready 1, dbg_ack 0, dbg_rdata 0, mem_write_en 0, holding register empty, counters 0.
- Loader holding register: one entry; captured when ldr_valid && ldr_ready; ldr_ready drops next cycle, rises the cycle after the write is issued. ldr_valid while !ldr_ready is dropped (loader contract forbids it).
- Pending = ldr_full || dbg_req. Priority: loader > debug > core.
- s_CORE: mem_* = core_*; core_en = core_run_req registered. If pending: core_en <= 0, counter <= DRAIN_CYCLES-1, go s_DRAIN.
- s_DRAIN: mem_* still = core_* (core may finish its cycle), mem_write_en forced 0 after first drain cycle; decrement; at 0 go s_GRANT.
- s_GRANT: if ldr_full -> s_LDR_WR; else if dbg_req -> dbg_we ? s_DBG_WR : s_DBG_RD (counter <= READ_LATENCY); else -> s_CORE.
- s_LDR_WR: one cycle, mem_addr/data = holding reg, mem_write_en 1; empty reg; -> s_GRANT.
- s_DBG_WR: one cycle write of dbg_addr/dbg_wdata; dbg_ack 1 next cycle; -> s_ACK.
- s_DBG_RD: mem_addr = dbg_addr, write_en 0, count READ_LATENCY cycles; on expiry capture mem_read_data into dbg_rdata, dbg_ack 1 -> s_ACK.
- s_ACK: one cycle gap (requester drops dbg_req); -> s_GRANT.
- Return to s_CORE only from s_GRANT with nothing pending; core_en re-asserts one cycle later if core_run_req.
- Back-to-back loader bytes stay in s_GRANT/s_LDR_WR loop without re-draining: 2 cycles/byte.
- core_run_req low in s_CORE: core_en 0 next cycle; no drain needed for later grants but drain still executed (uniform timing).
- rst mid-transaction: immediate return to reset values; held byte discarded; no dbg_ack.
- Simultaneous ldr capture and dbg_req: loader served first, then debug.

Test Plan:
- Reset, core_run_req=1 -> core_en=1 at cycle 2, mem_addr tracks core_addr, busy=0.
- Loader write 0x5A to 0x0F20 while core running -> core_en low, write after DRAIN_CYCLES+1 cycles, mem_write_en exactly one cycle, core_en back, busy pulse length DRAIN_CYCLES+3.
- 16 back-to-back loader bytes 0x0F00..0x0F0F -> one drain only, 2 cycles/byte, mmu contents match.
- Debug read of 0x0F05 with READ_LATENCY=2 -> dbg_ack single pulse, dbg_rdata=byte at 0x0F05, no write strobe.
- ldr_valid and dbg_req same cycle -> loader write precedes debug ack; core never enabled between.
- rst asserted during s_DBG_RD -> no dbg_ack, ldr_ready=1, core_en=0 next cycle.

Source files
------------

// File: rtl/mk14_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mk14_bus_arbiter : shares the MMU core-side port between the SC/MP core,
//                    the Intel-HEX loader and a debug read/write port.
// Revision: 1.0
// ============================================================================
module mk14_bus_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 1,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_run_req,
    output logic              core_en,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_write_en,
    input  logic [DATA_W-1:0] core_write_data,
    input  logic              ldr_valid,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_data,
    output logic              ldr_ready,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    typedef enum logic [2:0] {
        s_CORE   = 3'd0,
        s_DRAIN  = 3'd1,
        s_GRANT  = 3'd2,
        s_LDR_WR = 3'd3,
        s_DBG_WR = 3'd4,
        s_DBG_RD = 3'd5,
        s_ACK    = 3'd6
    } state_t;

    localparam logic [2:0] c_DRAIN_INIT = 3'(DRAIN_CYCLES - 1);
    localparam logic [2:0] c_RD_INIT    = 3'(READ_LATENCY);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_nxt;
    logic              r_core_en;
    logic              r_ldr_full;
    logic [ADDR_W-1:0] r_ldr_addr;
    logic [DATA_W-1:0] r_ldr_data;
    logic              r_dbg_ack;
    logic [DATA_W-1:0] r_dbg_rdata;

    logic              w_ldr_cap;
    logic              w_pending;
    logic              w_rd_done;

    assign w_ldr_cap = ldr_valid && !r_ldr_full;
    assign w_pending = r_ldr_full || dbg_req;
    assign w_rd_done = (r_state == s_DBG_RD) && (r_cnt == 3'd0);

    assign core_en   = r_core_en;
    assign ldr_ready = !r_ldr_full;
    assign dbg_ack   = r_dbg_ack;
    assign dbg_rdata = r_dbg_rdata;
    assign busy      = (r_state != s_CORE);

    always_comb begin
        mem_addr       = core_addr;
        mem_write_data = core_write_data;
        mem_write_en   = 1'b0;
        case (r_state)
            s_CORE:   mem_write_en = core_write_en && r_core_en;
            // The core may still complete a cycle it started on the last enabled clock.
            s_DRAIN:  mem_write_en = core_write_en && (r_cnt == c_DRAIN_INIT);
            s_LDR_WR: begin
                mem_addr       = r_ldr_addr;
                mem_write_data = r_ldr_data;
                mem_write_en   = 1'b1;
            end
            s_DBG_WR: begin
                mem_addr       = dbg_addr;
                mem_write_data = dbg_wdata;
                mem_write_en   = 1'b1;
            end
            s_DBG_RD: mem_addr = dbg_addr;
            s_ACK:    mem_addr = dbg_addr;
            default:  mem_write_en = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            s_CORE: begin
                if (w_pending) begin
                    w_state_nxt = s_DRAIN;
                    w_cnt_nxt   = c_DRAIN_INIT;
                end
            end
            s_DRAIN: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = s_GRANT;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            s_GRANT: begin
                // A byte arriving this cycle keeps the loader loop going without a re-drain.
                if (r_ldr_full || w_ldr_cap) begin
                    w_state_nxt = s_LDR_WR;
                end else if (dbg_req) begin
                    w_state_nxt = dbg_we ? s_DBG_WR : s_DBG_RD;
                    w_cnt_nxt   = c_RD_INIT;
                end else begin
                    w_state_nxt = s_CORE;
                end
            end
            s_LDR_WR: w_state_nxt = s_GRANT;
            s_DBG_WR: w_state_nxt = s_ACK;
            s_DBG_RD: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = s_ACK;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            s_ACK:    w_state_nxt = s_GRANT;
            default:  w_state_nxt = s_CORE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= s_CORE;
            r_cnt       <= 3'd0;
            r_core_en   <= 1'b0;
            r_ldr_full  <= 1'b0;
            r_ldr_addr  <= '0;
            r_ldr_data  <= '0;
            r_dbg_ack   <= 1'b0;
            r_dbg_rdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_core_en <= (r_state == s_CORE) && !w_pending && core_run_req;
            r_dbg_ack <= (r_state == s_DBG_WR) || w_rd_done;
            if (w_rd_done) begin
                r_dbg_rdata <= mem_read_data;
            end
            if (w_ldr_cap) begin
                r_ldr_full <= 1'b1;
                r_ldr_addr <= ldr_addr;
                r_ldr_data <= ldr_data;
            end else if (r_state == s_LDR_WR) begin
                r_ldr_full <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mk14_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mk14_bus_arbiter : scoreboard bench for mk14_bus_arbiter with an MMU
//                       stand-in and a reference memory image.
// Revision: 1.0
// ============================================================================
module tb_mk14_bus_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int RL = 2;
    localparam int DC = 2;

    logic          clk;
    logic          rst;
    logic          core_run_req;
    logic          core_en;
    logic [AW-1:0] core_addr;
    logic          core_write_en;
    logic [DW-1:0] core_write_data;
    logic          ldr_valid;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_data;
    logic          ldr_ready;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_write_en;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;
    logic          busy;

    mk14_bus_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .DRAIN_CYCLES(DC)
    ) dut (
        .clk(clk), .rst(rst), .core_run_req(core_run_req), .core_en(core_en),
        .core_addr(core_addr), .core_write_en(core_write_en),
        .core_write_data(core_write_data), .ldr_valid(ldr_valid),
        .ldr_addr(ldr_addr), .ldr_data(ldr_data), .ldr_ready(ldr_ready),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_write_en(mem_write_en),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .busy(busy)
    );

    typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
    typedef struct { bit is_rd; logic [15:0] a; logic [7:0] d; } ack_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   ncyc = 0;
    int   busy_rises = 0;
    int   ack_cyc = 0;
    int   last_wr_cyc = 0;
    logic prev_busy = 1'b0;
    int   wr_times[$];
    wr_t  exp_wr[$];
    ack_t exp_ack[$];
    wr_t  m_w;
    ack_t m_a;

    logic [7:0] mmu     [0:65535];
    logic [7:0] ref_mem [0:65535];
    logic [7:0] pipe    [0:RL-1];

    assign mem_read_data = pipe[RL-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MMU stand-in: synchronous write, RL-cycle read pipeline.
    initial begin
        for (int i = 0; i < 65536; i++) mmu[i] <= 8'(i * 7 + 3);
        for (int i = 0; i < RL; i++) pipe[i] <= '0;
        forever begin
            @(posedge clk);
            if (mem_write_en) mmu[mem_addr] <= mem_write_data;
            pipe[0] <= mmu[mem_addr];
            for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the arbiter issues a non-core write or an ack.
    always @(negedge clk) begin
        if (!rst) begin
            ncyc++;
            if (busy && !prev_busy) busy_rises++;
            prev_busy = busy;
            if (core_en) chk("core_en_while_busy", busy, 0);
            if (mem_write_en && busy) begin
                wr_times.push_back(ncyc);
                last_wr_cyc = ncyc;
                if (exp_wr.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                             mem_addr, mem_write_data);
                end else begin
                    m_w = exp_wr.pop_front();
                    chk("wr_addr", mem_addr, m_w.a);
                    chk("wr_data", mem_write_data, m_w.d);
                end
            end
            if (dbg_ack) begin
                ack_cyc = ncyc;
                if (exp_ack.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got dbg_ack=1 expected 0");
                end else begin
                    m_a = exp_ack.pop_front();
                    if (m_a.is_rd) chk("dbg_rdata", dbg_rdata, m_a.d);
                    else           chk("dbg_wr_mem", mmu[m_a.a], m_a.d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || !ldr_ready || core_en != core_run_req) && t < 200) begin
            tick();
            t++;
        end
        chk("idle_wait_timeout", t < 200, 1);
    endtask

    task automatic ldr_send(input logic [15:0] a, input logic [7:0] d);
        int  t = 0;
        wr_t w;
        while (!ldr_ready && t < 200) begin
            tick();
            t++;
        end
        chk("ldr_ready_timeout", t < 200, 1);
        ldr_addr   = a;
        ldr_data   = d;
        ldr_valid  = 1'b1;
        ref_mem[a] = d;
        w.a = a;
        w.d = d;
        exp_wr.push_back(w);
        tick();
        ldr_valid = 1'b0;
    endtask

    task automatic dbg_txn(input bit we, input logic [15:0] a, input logic [7:0] wd);
        int   t = 0;
        ack_t k;
        wr_t  w;
        k.is_rd = !we;
        k.a     = a;
        if (we) begin
            ref_mem[a] = wd;
            w.a = a;
            w.d = wd;
            exp_wr.push_back(w);
        end
        k.d = ref_mem[a];
        exp_ack.push_back(k);
        dbg_we    = we;
        dbg_addr  = a;
        dbg_wdata = wd;
        dbg_req   = 1'b1;
        while (!dbg_ack && t < 200) begin
            tick();
            t++;
        end
        chk("dbg_ack_timeout", t < 200, 1);
        dbg_req = 1'b0;
        tick();
        chk("dbg_ack_pulse", dbg_ack, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int fall, wr, wrn, bl, b0, s0, saw, t, mism;
        logic [7:0] sim_byte;
        wr_t w;
        ack_t k;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i * 7 + 3);
        rst = 1'b1; core_run_req = 1'b0; core_addr = '0; core_write_en = 1'b0;
        core_write_data = '0; ldr_valid = 1'b0; ldr_addr = '0; ldr_data = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_core_en", core_en, 0);
        chk("rst_ldr_ready", ldr_ready, 1);
        chk("rst_dbg_ack", dbg_ack, 0);
        chk("rst_dbg_rdata", dbg_rdata, 0);
        chk("rst_mem_we", mem_write_en, 0);
        chk("rst_busy", busy, 0);

        tick();
        core_run_req = 1'b1;
        core_addr    = 16'h0ABC;
        tick();
        @(negedge clk);
        chk("run_core_en", core_en, 1);
        chk("run_mem_addr", mem_addr, 16'h0ABC);

        tick();
        core_addr = 16'h1234; core_write_data = 8'hA5; core_write_en = 1'b1;
        ref_mem[16'h1234] = 8'hA5;
        @(negedge clk);
        chk("core_wr_en", mem_write_en, 1);
        chk("core_wr_addr", mem_addr, 16'h1234);
        chk("core_wr_data", mem_write_data, 8'hA5);
        tick();
        core_write_en = 1'b0;

        // Single loader byte: drain timing and busy width.
        wait_idle();
        ldr_addr = 16'h0F20; ldr_data = 8'h5A; ldr_valid = 1'b1;
        ref_mem[16'h0F20] = 8'h5A;
        w.a = 16'h0F20; w.d = 8'h5A;
        exp_wr.push_back(w);
        fall = -1; wr = -1; wrn = 0; bl = 0;
        for (int kk = 1; kk <= 20; kk++) begin
            tick();
            ldr_valid = 1'b0;
            @(negedge clk);
            if (!core_en && fall < 0) fall = kk;
            if (mem_write_en) begin
                wrn++;
                if (wr < 0) wr = kk;
            end
            if (busy) bl++;
        end
        chk("ldr_write_delay", wr - fall, DC + 1);
        chk("ldr_write_strobes", wrn, 1);
        chk("ldr_busy_len", bl, DC + 3);
        chk("ldr_core_en_back", core_en, 1);

        // Sixteen back-to-back loader bytes.
        tick();
        wait_idle();
        b0 = busy_rises;
        s0 = wr_times.size();
        for (int i = 0; i < 16; i++) ldr_send(16'h0F00 + 16'(i), 8'($urandom));
        wait_idle();
        chk("burst_drains", busy_rises - b0, 1);
        chk("burst_writes", wr_times.size() - s0, 16);
        if (wr_times.size() >= s0 + 16) chk("burst_span", wr_times[s0+15] - wr_times[s0], 30);
        for (int i = 0; i < 16; i++) chk("burst_mem", mmu[16'h0F00 + 16'(i)], ref_mem[16'h0F00 + 16'(i)]);

        dbg_txn(1'b0, 16'h0F05, 8'h00);
        repeat (3) tick();
        chk("dbg_rdata_hold", dbg_rdata, ref_mem[16'h0F05]);
        dbg_txn(1'b1, 16'h0F06, 8'h3C);
        dbg_txn(1'b0, 16'h0F06, 8'h00);

        // Core stopped: enable falls next cycle, later grants still work.
        wait_idle();
        core_run_req = 1'b0;
        tick();
        @(negedge clk);
        chk("core_en_drop", core_en, 0);
        chk("core_stop_busy", busy, 0);
        dbg_txn(1'b0, 16'h0F20, 8'h00);
        core_run_req = 1'b1;

        // Loader byte and debug read in the same cycle.
        wait_idle();
        sim_byte = 8'($urandom);
        ldr_addr = 16'h0F40; ldr_data = sim_byte; ldr_valid = 1'b1;
        ref_mem[16'h0F40] = sim_byte;
        w.a = 16'h0F40; w.d = sim_byte;
        exp_wr.push_back(w);
        k.is_rd = 1'b1; k.a = 16'h0F40; k.d = sim_byte;
        exp_ack.push_back(k);
        dbg_we = 1'b0; dbg_addr = 16'h0F40; dbg_req = 1'b1;
        tick();
        ldr_valid = 1'b0;
        saw = 0; t = 0;
        while (!dbg_ack && t < 200) begin
            if (core_en) saw = 1;
            tick();
            t++;
        end
        chk("sim_timeout", t < 200, 1);
        dbg_req = 1'b0;
        tick();
        chk("sim_core_en", saw, 0);
        chk("sim_order", last_wr_cyc < ack_cyc, 1);

        // Reset while a debug read is waiting on memory, with a byte held.
        wait_idle();
        dbg_we = 1'b0; dbg_addr = 16'h0F10; dbg_req = 1'b1;
        repeat (DC + 3) tick();
        ldr_addr = 16'h0F11; ldr_data = 8'hEE; ldr_valid = 1'b1;
        tick();
        ldr_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dbg_req = 1'b0;
        @(negedge clk);
        chk("rstmid_dbg_ack", dbg_ack, 0);
        chk("rstmid_ldr_ready", ldr_ready, 1);
        chk("rstmid_core_en", core_en, 0);
        chk("rstmid_busy", busy, 0);
        repeat (6) tick();

        // Randomised mix of loader bursts and debug transactions.
        for (int n = 0; n < 40; n++) begin
            int op;
            op = $urandom_range(0, 3);
            core_run_req = ($urandom_range(0, 3) != 0);
            core_addr    = 16'($urandom);
            if (op == 0) begin
                int len;
                len = $urandom_range(1, 4);
                for (int j = 0; j < len; j++)
                    ldr_send(16'h0F80 + 16'($urandom_range(0, 31)), 8'($urandom));
            end else if (op == 1) begin
                dbg_txn(1'b1, 16'h0F80 + 16'($urandom_range(0, 31)), 8'($urandom));
            end else begin
                dbg_txn(1'b0, 16'h0F80 + 16'($urandom_range(0, 31)), 8'h00);
            end
            repeat ($urandom_range(0, 3)) tick();
        end

        core_run_req = 1'b1;
        repeat (20) tick();
        wait_idle();
        chk("exp_wr_empty", exp_wr.size(), 0);
        chk("exp_ack_empty", exp_ack.size(), 0);
        mism = 0;
        for (int i = 16'h0F00; i < 16'h1000; i++) if (mmu[i] !== ref_mem[i]) mism++;
        if (mmu[16'h1234] !== ref_mem[16'h1234]) mism++;
        chk("mem_image", mism, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
